// File: rtl/noc_pkg.sv
// Shared packet format and serial-link constants for the byte-serial router link.
package noc_pkg;

  typedef struct packed {
    logic [3:0]  source_id;
    logic [3:0]  dest_id;
    logic [23:0] data;
  } pkt_t;

  localparam int PKT_BYTES = 4;
  localparam int BIDX_W    = $clog2(PKT_BYTES);

  // Byte idx of a packet on the wire, MSB first.
  function automatic logic [7:0] pkt_byte(input pkt_t p, input logic [BIDX_W-1:0] idx);
    return p[8*(PKT_BYTES-1-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous pkt_t queue with zero-latency head (0 when empty); push and pop in one cycle both honoured.
// Pushes while full and pops while empty are ignored; pointers wrap modulo DEPTH.
module pkt_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         i_wr,
  input  pkt_t                         i_wdat,
  input  logic                         i_rd,
  output pkt_t                         o_rdat,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  pkt_t          r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdat  = o_empty ? '0 : r_mem[r_rptr];
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= nxt(r_wptr);
      if (w_rd) r_rptr <= nxt(r_rptr);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_rd) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdat;
  end

endmodule

// File: rtl/node_port.sv
// Node endpoint of the router link: TX queue + MSB-first 4-byte serialiser, RX deserialiser + queue.
// First TX byte one cycle after start, 6-cycle packet period; free_out reserves a slot for any burst in flight.
module node_port
  import noc_pkg::*;
#(
  parameter int NODEID   = 0,
  parameter int TX_DEPTH = 2,
  parameter int RX_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_b,
  input  pkt_t       i_tx_pkt,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_put_out,
  output logic [7:0] o_payload_out,
  input  logic       i_free_in,
  input  logic       i_put_in,
  input  logic [7:0] i_payload_in,
  output logic       o_free_out,
  output pkt_t       o_rx_pkt,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_rx_misroute,
  output logic       o_rx_err
);
  localparam logic [1:0] TX_IDLE    = 2'd0;
  localparam logic [1:0] TX_SEND    = 2'd1;
  localparam logic [1:0] TX_GAP     = 2'd2;
  localparam logic [0:0] RX_WAIT    = 1'b0;
  localparam logic [0:0] RX_COLLECT = 1'b1;
  localparam int TXCW = $clog2(TX_DEPTH+1);
  localparam int RXCW = $clog2(RX_DEPTH+1);

  logic [1:0]        r_tx_state;
  pkt_t              r_tx_pkt;
  logic [BIDX_W-1:0] r_tx_idx;
  logic              r_put_out;
  logic [7:0]        r_payload_out;
  pkt_t              w_tx_head;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_pop;
  logic [TXCW-1:0]   w_tx_count;

  logic [0:0]        r_rx_state;
  logic [31:8]       r_rx_sreg;
  logic [BIDX_W-1:0] r_rx_cnt;
  logic              r_rx_drop;
  logic              r_rx_wr;
  pkt_t              r_rx_wdat;
  logic              r_rx_misroute;
  logic              r_rx_err;
  pkt_t              w_rx_pkt;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_rx_busy;
  logic [RXCW-1:0]   w_rx_count;

  assign o_tx_ready    = ~w_tx_full;
  assign w_tx_pop      = (r_tx_state == TX_IDLE) & ~w_tx_empty & i_free_in;
  assign o_put_out     = r_put_out;
  assign o_payload_out = r_payload_out;

  pkt_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_b(rst_b), .i_wr(i_tx_valid), .i_wdat(i_tx_pkt), .i_rd(w_tx_pop),
    .o_rdat(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  // free_in only gates the start of a burst; a started burst always runs to completion.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_tx_state    <= TX_IDLE;
      r_tx_pkt      <= '0;
      r_tx_idx      <= '0;
      r_put_out     <= 1'b0;
      r_payload_out <= '0;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          r_tx_state    <= TX_SEND;
          r_tx_pkt      <= w_tx_head;
          r_tx_idx      <= '0;
          r_put_out     <= 1'b1;
          r_payload_out <= pkt_byte(w_tx_head, '0);
        end
        TX_SEND: if (r_tx_idx == BIDX_W'(PKT_BYTES-1)) begin
          r_tx_state    <= TX_GAP;
          r_put_out     <= 1'b0;
          r_payload_out <= '0;
        end else begin
          r_tx_idx      <= r_tx_idx + BIDX_W'(1);
          r_payload_out <= pkt_byte(r_tx_pkt, r_tx_idx + BIDX_W'(1));
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign w_rx_pkt   = {r_rx_sreg, i_payload_in};
  assign w_rx_busy  = (r_rx_state == RX_COLLECT) | r_rx_wr;
  assign o_free_out = ({1'b0, w_rx_count} + (RXCW+1)'(w_rx_busy)) < (RXCW+1)'(RX_DEPTH);
  assign o_rx_valid    = ~w_rx_empty;
  assign o_rx_misroute = r_rx_misroute;
  assign o_rx_err      = r_rx_err;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_rx_state    <= RX_WAIT;
      r_rx_sreg     <= '0;
      r_rx_cnt      <= '0;
      r_rx_drop     <= 1'b0;
      r_rx_wr       <= 1'b0;
      r_rx_wdat     <= '0;
      r_rx_misroute <= 1'b0;
      r_rx_err      <= 1'b0;
    end else begin
      r_rx_wr       <= 1'b0;
      r_rx_misroute <= 1'b0;
      r_rx_err      <= 1'b0;
      case (r_rx_state)
        RX_WAIT: if (i_put_in) begin
          r_rx_state <= RX_COLLECT;
          r_rx_sreg  <= {i_payload_in, 16'h0};
          r_rx_cnt   <= BIDX_W'(1);
          r_rx_drop  <= ~o_free_out;
        end
        default: if (!i_put_in) begin
          r_rx_state <= RX_WAIT;
          r_rx_err   <= 1'b1;
        end else if (r_rx_cnt == BIDX_W'(PKT_BYTES-1)) begin
          // Misrouted packets are still delivered; the pulse only flags them.
          r_rx_state    <= RX_WAIT;
          r_rx_wr       <= ~r_rx_drop;
          r_rx_wdat     <= w_rx_pkt;
          r_rx_misroute <= ~r_rx_drop & (w_rx_pkt.dest_id != 4'(NODEID));
        end else begin
          r_rx_sreg[8*(PKT_BYTES-1-int'(r_rx_cnt)) +: 8] <= i_payload_in;
          r_rx_cnt <= r_rx_cnt + BIDX_W'(1);
        end
      endcase
    end
  end

  pkt_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_b(rst_b), .i_wr(r_rx_wr), .i_wdat(r_rx_wdat), .i_rd(i_rx_ready),
    .o_rdat(o_rx_pkt), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  a_rx_burst_fits: assert property (@(posedge clk) disable iff (rst_b)
    (r_rx_state == RX_WAIT && i_put_in) |-> o_free_out);
  a_rx_no_overflow: assert property (@(posedge clk) disable iff (rst_b)
    r_rx_wr |-> !w_rx_full);
  a_tx_count: assert property (@(posedge clk) disable iff (rst_b)
    w_tx_full == (w_tx_count == TXCW'(TX_DEPTH)));

endmodule

// File: tb/tb_node_port.sv
// Directed and randomized bench for node_port against a queue/schedule reference model.
module tb_node_port;
  import noc_pkg::*;

  localparam int NODEID   = 3;
  localparam int TX_DEPTH = 2;
  localparam int RX_DEPTH = 2;

  logic       clk;
  logic       rst_b;
  pkt_t       tx_pkt;
  logic       tx_valid;
  logic       tx_ready;
  logic       put_out;
  logic [7:0] payload_out;
  logic       free_in;
  logic       put_in;
  logic [7:0] payload_in;
  logic       free_out;
  pkt_t       rx_pkt;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_misroute;
  logic       rx_err;

  node_port #(.NODEID(NODEID), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst_b(rst_b),
    .i_tx_pkt(tx_pkt), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_put_out(put_out), .o_payload_out(payload_out), .i_free_in(free_in),
    .i_put_in(put_in), .i_payload_in(payload_in), .o_free_out(free_out),
    .o_rx_pkt(rx_pkt), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .o_rx_misroute(rx_misroute), .o_rx_err(rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: packet queues plus a schedule of bytes due on the wire.
  logic [31:0] m_txq[$];
  logic [7:0]  m_sched[$];
  int          m_busy;
  logic [31:0] m_rxq[$];
  logic [7:0]  m_rxb[$];
  bit          m_pend;
  logic [31:0] m_pend_pkt;
  bit          m_put;
  logic [7:0]  m_pay;
  bit          m_misr;
  bit          m_err;

  logic [7:0]  cap[$];
  int          n_misr;
  int          n_rxerr;

  function automatic bit m_free_out();
    int busy;
    busy = (m_rxb.size() > 0 || m_pend) ? 1 : 0;
    return (RX_DEPTH - m_rxq.size() - busy) >= 1;
  endfunction

  task automatic m_reset();
    m_txq.delete(); m_sched.delete(); m_rxq.delete(); m_rxb.delete();
    m_busy = 0; m_pend = 0; m_pend_pkt = '0;
    m_put = 0; m_pay = '0; m_misr = 0; m_err = 0;
  endtask

  task automatic m_edge();
    bit can_push;
    logic [31:0] p;
    can_push = m_txq.size() < TX_DEPTH;
    if (m_busy > 0) m_busy--;
    else if (m_txq.size() > 0 && free_in) begin
      p = m_txq.pop_front();
      for (int b = 0; b < 4; b++) m_sched.push_back(p[31-8*b -: 8]);
      m_busy = 5;
    end
    if (tx_valid && can_push) m_txq.push_back(tx_pkt);
    m_put = m_sched.size() > 0;
    m_pay = m_put ? m_sched.pop_front() : 8'h00;

    m_misr = 0;
    m_err  = 0;
    if (m_rxq.size() > 0 && rx_ready) void'(m_rxq.pop_front());
    if (m_pend) m_rxq.push_back(m_pend_pkt);
    m_pend = 0;
    if (m_rxb.size() > 0) begin
      if (put_in) begin
        m_rxb.push_back(payload_in);
        if (m_rxb.size() == 4) begin
          m_pend_pkt = {m_rxb[0], m_rxb[1], m_rxb[2], m_rxb[3]};
          m_pend = 1;
          m_misr = m_pend_pkt[27:24] != 4'(NODEID);
          m_rxb.delete();
        end
      end else begin
        m_err = 1;
        m_rxb.delete();
      end
    end else if (put_in) begin
      m_rxb.push_back(payload_in);
    end
  endtask

  task automatic check_outputs();
    check_eq("tx_ready", 32'(tx_ready), 32'(m_txq.size() < TX_DEPTH));
    check_eq("put_out", 32'(put_out), 32'(m_put));
    check_eq("payload_out", 32'(payload_out), 32'(m_pay));
    check_eq("free_out", 32'(free_out), 32'(m_free_out()));
    check_eq("rx_valid", 32'(rx_valid), 32'(m_rxq.size() > 0));
    check_eq("rx_pkt", rx_pkt, (m_rxq.size() > 0) ? m_rxq[0] : 32'h0);
    check_eq("rx_misroute", 32'(rx_misroute), 32'(m_misr));
    check_eq("rx_err", 32'(rx_err), 32'(m_err));
  endtask

  task automatic step();
    if (rst_b) m_reset();
    else m_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    if (put_out) cap.push_back(payload_out);
    if (rx_misroute) n_misr++;
    if (rx_err) n_rxerr++;
  endtask

  task automatic rx_burst(input logic [31:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      put_in = 1'b1;
      payload_in = p[31-8*i -: 8];
      step();
    end
    put_in = 1'b0;
    payload_in = 8'h00;
    step();
  endtask

  initial begin
    logic [31:0] exp_pkt;
    int drv_left;
    bit drv_trunc;
    int len;
    logic [3:0] dest;

    rst_b = 1'b1; tx_pkt = '0; tx_valid = 1'b0; free_in = 1'b0;
    put_in = 1'b0; payload_in = 8'h00; rx_ready = 1'b0;
    n_misr = 0; n_rxerr = 0;
    m_reset();
    step();
    step();
    rst_b = 1'b0;
    step();

    // Single packet, link free.
    cap.delete();
    free_in = 1'b1; tx_valid = 1'b1; tx_pkt = pkt_t'(32'h25A1B2C3);
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check_eq("tp1_len", 32'(cap.size()), 32'd4);
    exp_pkt = 32'h25A1B2C3;
    for (int i = 0; i < 4; i++)
      if (i < cap.size()) check_eq($sformatf("tp1_b%0d", i), 32'(cap[i]), 32'(exp_pkt[31-8*i -: 8]));
    check_eq("tp1_idle", 32'(put_out), 32'd0);

    // Fill TX queue with link blocked, third push must be dropped.
    cap.delete();
    free_in = 1'b0;
    tx_valid = 1'b1; tx_pkt = pkt_t'(32'hA0B0C0D0); step();
    tx_pkt = pkt_t'(32'h01020304); step();
    tx_pkt = pkt_t'(32'hEEEEEEEE); step();
    tx_valid = 1'b0;
    check_eq("tp2_full", 32'(tx_ready), 32'd0);
    check_eq("tp2_blocked", 32'(cap.size()), 32'd0);
    free_in = 1'b1;
    for (int i = 0; i < 16; i++) step();
    check_eq("tp2_len", 32'(cap.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_pkt = (i < 4) ? 32'hA0B0C0D0 : 32'h01020304;
      if (i < cap.size()) check_eq($sformatf("tp2_b%0d", i), 32'(cap[i]), 32'(exp_pkt[31-8*(i%4) -: 8]));
    end

    // RX good packets until the queue blocks the link.
    n_misr = 0;
    rx_burst(32'h1300007F, 4);
    step();
    check_eq("tp3_valid", 32'(rx_valid), 32'd1);
    check_eq("tp3_pkt", rx_pkt, 32'h1300007F);
    rx_burst(32'h1300007F, 4);
    step();
    check_eq("tp3_free", 32'(free_out), 32'd0);
    check_eq("tp3_misr", 32'(n_misr), 32'd0);
    rx_ready = 1'b1; step(); step(); rx_ready = 1'b0;
    check_eq("tp3_drained", 32'(rx_valid), 32'd0);

    // Misrouted packet is still queued.
    rx_burst(32'h14112233, 4);
    step();
    check_eq("tp4_pkt", rx_pkt, 32'h14112233);
    check_eq("tp4_misr", 32'(n_misr), 32'd1);
    rx_ready = 1'b1; step(); rx_ready = 1'b0;

    // Truncated burst.
    n_rxerr = 0;
    rx_burst(32'h13AABBCC, 2);
    step();
    check_eq("tp5_err", 32'(n_rxerr), 32'd1);
    check_eq("tp5_valid", 32'(rx_valid), 32'd0);
    check_eq("tp5_free", 32'(free_out), 32'd1);

    // Asynchronous reset in the middle of a TX and an RX burst.
    free_in = 1'b1; tx_valid = 1'b1; tx_pkt = pkt_t'(32'h5A6B7C8D);
    step();
    tx_valid = 1'b0;
    step();
    step();
    put_in = 1'b1; payload_in = 8'h13;
    step();
    payload_in = 8'h00;
    check_eq("tp6_pre_put", 32'(put_out), 32'd1);
    check_eq("tp6_pre_byte", 32'(payload_out), 32'h7C);
    rst_b = 1'b1;
    #1;
    check_eq("tp6_rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("tp6_rst_put", 32'(put_out), 32'd0);
    check_eq("tp6_rst_payload", 32'(payload_out), 32'd0);
    check_eq("tp6_rst_free", 32'(free_out), 32'd1);
    check_eq("tp6_rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("tp6_rst_rx_pkt", rx_pkt, 32'd0);
    check_eq("tp6_rst_misr", 32'(rx_misroute), 32'd0);
    check_eq("tp6_rst_err", 32'(rx_err), 32'd0);
    put_in = 1'b0;
    step();
    step();
    rst_b = 1'b0;
    cap.delete(); n_rxerr = 0;
    for (int i = 0; i < 10; i++) step();
    check_eq("tp6_no_tx", 32'(cap.size()), 32'd0);
    check_eq("tp6_no_rx", 32'(rx_valid), 32'd0);
    check_eq("tp6_no_err", 32'(n_rxerr), 32'd0);

    // Randomized traffic; the RX driver only starts a burst while free_out is high.
    drv_left = 0;
    drv_trunc = 0;
    for (int c = 0; c < 2000; c++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_pkt = pkt_t'($urandom);
      free_in = ($urandom_range(0, 9) < 7);
      rx_ready = 1'($urandom_range(0, 1));
      payload_in = 8'($urandom);
      if (drv_left > 0) begin
        put_in = 1'b1;
        drv_left--;
      end else if (drv_trunc) begin
        put_in = 1'b0;
        drv_trunc = 0;
      end else if (m_free_out() && $urandom_range(0, 3) == 0) begin
        len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4;
        dest = ($urandom_range(0, 1) == 1) ? 4'(NODEID) : 4'($urandom_range(0, 15));
        put_in = 1'b1;
        payload_in = {4'($urandom_range(0, 15)), dest};
        drv_left = len - 1;
        drv_trunc = (len < 4);
      end else begin
        put_in = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
